f_le_serial_responder: RTL and testbench
========================================

Name: f_le_serial_responder

Overview:
Responder end of the f_less_or_equal request interface. It serves one "a <= b" query at a time for FP64 operands and answers with res/err. Magnitudes are compared serially in CHUNK-bit slices, MSB first, under an FSM. It sits beside the sorting FSMs as a shared, area-lean comparator behind a valid/ready handshake.

Parameters:
FLEN, 64, operand width (IEEE 754 binary format; sign is bit FLEN-1)
EXP_W, 11, exponent field width; fraction width = FLEN-1-EXP_W
CHUNK, 16, magnitude slice width per compare cycle; FLEN % CHUNK == 0 required

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept; high only in IDLE
req_a  input  FLEN  operand a
req_b  input  FLEN  operand b
rsp_valid  output  1  one-cycle pulse: result valid
rsp_res  output  1  1 when a <= b
rsp_err  output  1  1 when either operand is NaN
busy  output  1  state != IDLE

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_res 0, rsp_err 0, busy 0, operand/slice registers 0.
- Handshake: accept when req_valid & req_ready at a rising edge (edge t). Capture req_a/req_b and go to CLASSIFY. req_valid while not ready is ignored. The requester must hold its request until accepted.
- CLASSIFY (cycle t+1):
  - NaN = exponent all ones and fraction != 0. If either operand is NaN: err=1, res=0, go to DONE.
  - Both magnitudes zero (sign ignored, so +0 == -0): res=1, go to DONE.
  - Signs differ: res = sign_a (negative a is less), go to DONE.
  - Otherwise clear the slice index and go to COMPARE.
- COMPARE: magnitude = operand with the sign bit forced to 0, full FLEN width. Slice k covers bits FLEN-1-k*CHUNK down to FLEN-(k+1)*CHUNK; compare one slice per cycle.
  - If the slices differ: lt = (slice_a < slice_b), go to DONE.
  - If equal and k is the last slice: magnitudes are equal, res=1, go to DONE.
  - Otherwise k++ and stay in COMPARE.
- Result for equal signs: positive gives res = (mag_a <= mag_b); negative gives res = (mag_a >= mag_b).
- DONE: rsp_valid=1 for exactly this cycle; next state IDLE. There is no response backpressure.
- rsp_res/rsp_err update only on entering DONE and hold until the next DONE.
- Latency from accept edge t to the rsp_valid cycle:
  - short-circuit in CLASSIFY: t+2
  - first differing slice k: t+3+k
  - full-equal magnitudes: t+2+FLEN/CHUNK (t+6 with defaults)
- Back-to-back: req_ready returns the cycle after DONE, so the next accept is possible at the edge ending that cycle.
- rst in any state: immediate return to IDLE, the pending request is discarded, no rsp_valid is produced, and outputs take their reset values.
- Slice index width: $clog2(FLEN/CHUNK). It never wraps: the exit is taken on the last slice.

Decomposition:
- Shared package f_le_pkg:
  - state enum {IDLE, CLASSIFY, COMPARE, DONE}
  - derived constants FRAC_W and NSLICE
  - functions is_nan, is_zero_mag
- One natural sub-module: f_le_slice_cmp, a combinational CHUNK-bit compare giving eq/lt. Inlining it is acceptable.

Test Plan:
1. a=0x3FF0000000000000 (1.0), b=0x4000000000000000 (2.0) -> differ at slice 0; rsp_valid at t+3, res=1, err=0.
2. a=0x8000000000000000 (-0), b=0x0 (+0) -> CLASSIFY zero short-circuit; rsp_valid at t+2, res=1. Swapping the operands also gives res=1.
3. a=0x7FF8000000000000 (NaN), b=1.0 -> rsp_valid at t+2, err=1, res=0. Same result with b=NaN.
4. a=b=0xC000000000000001 -> all 4 slices equal; rsp_valid at t+6, res=1.
5. a=0xC008000000000000 (-3.0), b=0xC000000000000000 (-2.0) -> res=1 at t+3. Swapping the operands gives res=0.
6. Accept 1.0 vs 2.0, assert rst during COMPARE -> no rsp_valid. Next cycle: req_ready=1, rsp_res=0, rsp_err=0, busy=0. Also drive req_valid while busy -> request ignored, exactly one response for the accepted query.

Source files
------------

// File: rtl/f_le_pkg.sv
// f_le_pkg
// Shared definitions for the serial FP "a <= b" responder: FSM state
// encoding, default format constants and IEEE 754 classification helpers.
package f_le_pkg;

  localparam int F_LE_FLEN  = 64;
  localparam int F_LE_EXP_W = 11;
  localparam int F_LE_CHUNK = 16;
  localparam int FRAC_W     = F_LE_FLEN - 1 - F_LE_EXP_W;
  localparam int NSLICE     = F_LE_FLEN / F_LE_CHUNK;

  typedef enum logic [1:0] {
    IDLE,
    CLASSIFY,
    COMPARE,
    DONE
  } state_e;

  // NaN: exponent all ones with a non-zero fraction (infinities are ordered).
  function automatic logic is_nan(input logic [F_LE_EXP_W-1:0] exp_f,
                                  input logic [FRAC_W-1:0]     frac_f);
    return (&exp_f) & (|frac_f);
  endfunction

  // Magnitude (everything below the sign bit) is zero, so +0 and -0 match.
  function automatic logic is_zero_mag(input logic [F_LE_FLEN-2:0] mag);
    return ~|mag;
  endfunction

endpackage

// File: rtl/f_le_slice_cmp.sv
// f_le_slice_cmp
// Combinational unsigned compare of one magnitude slice.
//   a, b : CHUNK-bit slices of the two magnitudes
//   eq   : a == b
//   lt   : a <  b
module f_le_slice_cmp #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/f_le_serial_responder.sv
// f_le_serial_responder
// Answers one FP "a <= b" query at a time. NaN, double-zero and mixed-sign
// cases are resolved in a single classify cycle; otherwise the magnitudes are
// compared one CHUNK-bit slice per cycle, most significant slice first.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : request present; req_a/req_b captured when req_ready is high
//   req_ready  : high only while idle
//   rsp_valid  : one-cycle pulse when rsp_res/rsp_err carry a fresh answer
//   rsp_res    : 1 when a <= b (held until the next answer)
//   rsp_err    : 1 when either operand is NaN (held until the next answer)
//   busy       : a query is in flight
module f_le_serial_responder
  import f_le_pkg::*;
#(
  parameter int FLEN  = F_LE_FLEN,
  parameter int EXP_W = F_LE_EXP_W,
  parameter int CHUNK = F_LE_CHUNK
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [FLEN-1:0] req_a,
  input  logic [FLEN-1:0] req_b,
  output logic            rsp_valid,
  output logic            rsp_res,
  output logic            rsp_err,
  output logic            busy
);

  localparam int NS    = FLEN / CHUNK;
  localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NS - 1);

  state_e            state_q, state_d;
  logic [FLEN-1:0]   a_q, a_d;
  logic [FLEN-1:0]   b_q, b_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              res_q, res_d;
  logic              err_q, err_d;

  logic              nan_a, nan_b, zero_both, sign_a, sign_b;
  logic [FLEN-1:0]   mag_a, mag_b;
  logic [CHUNK-1:0]  sl_a [NS];
  logic [CHUNK-1:0]  sl_b [NS];
  logic              slice_eq, slice_lt;

  assign sign_a    = a_q[FLEN-1];
  assign sign_b    = b_q[FLEN-1];
  assign nan_a     = is_nan(a_q[FLEN-2 -: EXP_W], a_q[FLEN-2-EXP_W:0]);
  assign nan_b     = is_nan(b_q[FLEN-2 -: EXP_W], b_q[FLEN-2-EXP_W:0]);
  assign zero_both = is_zero_mag(a_q[FLEN-2:0]) & is_zero_mag(b_q[FLEN-2:0]);

  assign mag_a = {1'b0, a_q[FLEN-2:0]};
  assign mag_b = {1'b0, b_q[FLEN-2:0]};

  // Slice 0 is the most significant CHUNK bits of the magnitude.
  for (genvar k = 0; k < NS; k++) begin : g_slice
    assign sl_a[k] = mag_a[FLEN-1-k*CHUNK -: CHUNK];
    assign sl_b[k] = mag_b[FLEN-1-k*CHUNK -: CHUNK];
  end

  f_le_slice_cmp #(.CHUNK(CHUNK)) u_slice_cmp (
    .a  (sl_a[idx_q]),
    .b  (sl_b[idx_q]),
    .eq (slice_eq),
    .lt (slice_lt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        if (nan_a | nan_b) begin
          err_d   = 1'b1;
          res_d   = 1'b0;
          state_d = DONE;
        end else if (zero_both) begin
          err_d   = 1'b0;
          res_d   = 1'b1;
          state_d = DONE;
        end else if (sign_a != sign_b) begin
          // The negative operand is the smaller one.
          err_d   = 1'b0;
          res_d   = sign_a;
          state_d = DONE;
        end else begin
          idx_d   = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (!slice_eq) begin
          // Larger magnitude is the smaller value when both are negative.
          err_d   = 1'b0;
          res_d   = sign_a ? ~slice_lt : slice_lt;
          state_d = DONE;
        end else if (idx_q == LAST_IDX) begin
          err_d   = 1'b0;
          res_d   = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_res   = res_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_f_le_serial_responder.sv
module tb_f_le_serial_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_res;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [63:0] ONE   = 64'h3FF0000000000000;
  localparam logic [63:0] TWO   = 64'h4000000000000000;
  localparam logic [63:0] NZERO = 64'h8000000000000000;
  localparam logic [63:0] PZERO = 64'h0000000000000000;
  localparam logic [63:0] QNAN  = 64'h7FF8000000000000;
  localparam logic [63:0] NEGX  = 64'hC000000000000001;
  localparam logic [63:0] NEG3  = 64'hC008000000000000;
  localparam logic [63:0] NEG2  = 64'hC000000000000000;
  localparam logic [63:0] PINF  = 64'h7FF0000000000000;

  f_le_serial_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_res   (rsp_res),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: the answer comes from real-number comparison; latency comes
  // from how far the query gets (classify only, first differing 16-bit
  // magnitude slice, or all slices equal).
  function automatic void ref_le(input logic [63:0] a, input logic [63:0] b,
                                 output bit err, output bit res, output int lat);
    bit na, nb;
    logic [63:0] ma, mb;
    na  = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
    nb  = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
    err = na || nb;
    res = err ? 1'b0 : ($bitstoreal(a) <= $bitstoreal(b));
    ma  = {1'b0, a[62:0]};
    mb  = {1'b0, b[62:0]};
    if (err || (ma == 0 && mb == 0) || (a[63] != b[63])) begin
      lat = 2;
    end else begin
      lat = 6;
      for (int k = 3; k >= 0; k--)
        if (ma[63-16*k -: 16] != mb[63-16*k -: 16]) lat = 3 + k;
    end
  endfunction

  task automatic query(input logic [63:0] a, input logic [63:0] b, input string tag);
    bit e_err, e_res, seen;
    int e_lat, n;
    ref_le(a, b, e_err, e_res, e_lat);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n    = 1;
    seen = 1'b0;
    while (n <= 12) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, seen ? 64'(n) : 64'd99, 64'(e_lat));
    if (seen) begin
      check({tag, "_res"}, 64'(rsp_res), 64'(e_res));
      check({tag, "_err"}, 64'(rsp_err), 64'(e_err));
      @(negedge clk);
      check({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
      check({tag, "_hold"}, {62'd0, rsp_err, rsp_res}, {62'd0, e_err, e_res});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, n, mode;
    logic [63:0] ra, rb;
    bit e_err, e_res;
    int e_lat;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_res",   64'(rsp_res),   64'd0);
    check("rst_err",   64'(rsp_err),   64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    rst = 1'b0;
    @(negedge clk);

    query(ONE,   TWO,   "one_two");
    query(NZERO, PZERO, "nz_pz");
    query(PZERO, NZERO, "pz_nz");
    query(QNAN,  ONE,   "nan_a");
    query(ONE,   QNAN,  "nan_b");
    query(NEGX,  NEGX,  "neg_eq");
    query(NEG3,  NEG2,  "neg3_neg2");
    query(NEG2,  NEG3,  "neg2_neg3");
    query(TWO,   ONE,   "two_one");
    query(PINF,  ONE,   "inf_one");
    query(NEG2,  ONE,   "mixed_sign");

    // Reset while comparing: nothing is answered, outputs go to reset values.
    query(ONE, TWO, "pre_rst");
    req_valid = 1'b1;
    req_a     = ONE;
    req_b     = TWO;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_valid", 64'(rsp_valid), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    check("rst_mid_busy0", 64'(busy),      64'd0);
    check("rst_mid_res",   64'(rsp_res),   64'd0);
    check("rst_mid_err",   64'(rsp_err),   64'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("rst_mid_norsp", 64'(cnt), 64'd0);

    // A request presented while busy must be ignored.
    req_valid = 1'b1;
    req_a     = NEGX;
    req_b     = NEGX;
    @(posedge clk);
    cnt = 0;
    n   = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i <= 4) begin
        req_valid = 1'b1;
        req_a     = QNAN;
        req_b     = ONE;
      end else begin
        req_valid = 1'b0;
      end
      if (rsp_valid) begin
        cnt++;
        n = i;
        check("busy_ign_res", {62'd0, rsp_err, rsp_res}, 64'd1);
      end
    end
    check("busy_ign_count", 64'(cnt), 64'd1);
    check("busy_ign_lat",   64'(n),   64'd6);

    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 4);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case (mode)
        1: rb = {ra[63:52], rb[51:0]};
        2: rb = ra;
        3: begin
          if ($urandom_range(0, 1) == 1) ra = {ra[63], 11'h7FF, ($urandom_range(0, 1) == 1) ? ra[51:0] : 52'd0};
          else ra = {ra[63], 63'd0};
          if ($urandom_range(0, 1) == 1) rb = {rb[63], 63'd0};
        end
        4: begin
          rb = ra;
          rb[$urandom_range(0, 47)] ^= 1'b1;
        end
        default: ;
      endcase
      ref_le(ra, rb, e_err, e_res, e_lat);
      query(ra, rb, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
